colour_decode: RTL and testbench

COLOUR_DECODE -- requirements
Module: colour_decode

---
 rtl/colour_decode.sv | 205 ++++++++++++++++++++
 tb/tb_colour_decode.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/colour_decode.sv
// RGB to hue/brightness decoder. The hue fraction comes from a 14-cycle restoring divider.
// Define COLOUR_DECODE_ROUND_EN to round the fraction to nearest instead of truncating it.
module colour_decode (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  red,
    input  logic [7:0]  green,
    input  logic [7:0]  blue,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] phase,
    output logic [7:0]  log_mag
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    logic [7:0]  max_s;
    logic [7:0]  min_s;
    logic [7:0]  num_s;
    logic [7:0]  delta_s;
    logic [2:0]  sector_s;
    logic [21:0] dividend_s;

    logic [7:0]  rem_r;
    logic [13:0] quo_r;
    logic [7:0]  delta_r;
    logic [2:0]  sector_r;
    logic [3:0]  cnt_r;
    logic [15:0] phase_r;
    logic [7:0]  log_mag_r;

    logic [8:0]  trial_s;
    logic [7:0]  rem_next_s;
    logic [13:0] quo_next_s;

    function automatic logic [15:0] sector_base(input logic [2:0] sector);
        case (sector)
            3'd0:    sector_base = 16'd0;
            3'd1:    sector_base = 16'd10922;
            3'd2:    sector_base = 16'd21844;
            3'd3:    sector_base = 16'd32766;
            3'd4:    sector_base = 16'd43688;
            3'd5:    sector_base = 16'd54610;
            default: sector_base = 16'd0;
        endcase
    endfunction

    // Sector, numerator, max and min of the incoming sample; rule order settles ties.
    always_comb begin
        max_s    = red;
        min_s    = red;
        num_s    = 8'd0;
        sector_s = 3'd0;
        if (red >= green && red >= blue) begin
            max_s = red;
            if (green >= blue) begin
                sector_s = 3'd0;
                num_s    = green - blue;
                min_s    = blue;
            end else begin
                sector_s = 3'd5;
                num_s    = red - blue;
                min_s    = green;
            end
        end else if (green >= blue) begin
            max_s = green;
            if (blue >= red) begin
                sector_s = 3'd2;
                num_s    = blue - red;
                min_s    = red;
            end else begin
                sector_s = 3'd1;
                num_s    = green - red;
                min_s    = blue;
            end
        end else begin
            max_s = blue;
            if (red >= green) begin
                sector_s = 3'd4;
                num_s    = red - green;
                min_s    = green;
            end else begin
                sector_s = 3'd3;
                num_s    = blue - green;
                min_s    = red;
            end
        end
    end

    assign delta_s = max_s - min_s;

    // Quotient never exceeds 10922 < 2^14, so dividend[21:14] is already below delta.
`ifdef COLOUR_DECODE_ROUND_EN
    assign dividend_s = ({14'd0, num_s} * 22'd10922) + {15'd0, delta_s[7:1]};
`else
    assign dividend_s = {14'd0, num_s} * 22'd10922;
`endif

    // One restoring-division step: quotient bits shift in as dividend bits shift out.
    always_comb begin
        trial_s = {rem_r, quo_r[13]};
        if (trial_s >= {1'b0, delta_r}) begin
            rem_next_s = 8'(trial_s - {1'b0, delta_r});
            quo_next_s = {quo_r[12:0], 1'b1};
        end else begin
            rem_next_s = trial_s[7:0];
            quo_next_s = {quo_r[12:0], 1'b0};
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; grey samples skip the divider.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (delta_s == 8'd0) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = DIVIDE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            DIVIDE: begin
                if (cnt_r == 4'd13) begin
                    next_state_s = DONE;
                end else begin
                    next_state_s = DIVIDE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Datapath: load on accept, iterate in DIVIDE, publish phase on the last step.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_r     <= 8'd0;
            quo_r     <= 14'd0;
            delta_r   <= 8'd0;
            sector_r  <= 3'd0;
            cnt_r     <= 4'd0;
            phase_r   <= 16'd0;
            log_mag_r <= 8'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        log_mag_r <= max_s;
                        phase_r   <= 16'd0;
                        delta_r   <= delta_s;
                        sector_r  <= sector_s;
                        rem_r     <= dividend_s[21:14];
                        quo_r     <= dividend_s[13:0];
                        cnt_r     <= 4'd0;
                    end
                end
                DIVIDE: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    cnt_r <= cnt_r + 4'd1;
                    if (cnt_r == 4'd13) begin
                        phase_r <= sector_base(sector_r) + {2'b00, quo_next_s};
                    end
                end
                default: begin
                    phase_r <= phase_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign phase     = phase_r;
    assign log_mag   = log_mag_r;

endmodule

// File: tb/tb_colour_decode.sv
// Self-checking bench for colour_decode: directed corner cases, backpressure,
// asynchronous reset mid-division and randomized samples against a hue model.
module tb_colour_decode;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] phase;
    logic [7:0]  log_mag;

    int checks   = 0;
    int failures = 0;

    colour_decode dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .phase     (phase),
        .log_mag   (log_mag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Hue model: ordered rule list, plain integer division.
    task automatic model(input int r, input int g, input int b,
                         output int ph, output int lm, output int lat);
        int mx, mn, d, sec, num, q;
        mx = (r > g) ? r : g;
        mx = (mx > b) ? mx : b;
        mn = (r < g) ? r : g;
        mn = (mn < b) ? mn : b;
        d  = mx - mn;
        lm = mx;
        if (d == 0) begin
            ph  = 0;
            lat = 1;
        end else begin
            if (r >= g && r >= b && g >= b)  begin sec = 0; num = g - b; end
            else if (r >= g && r >= b)       begin sec = 5; num = r - b; end
            else if (g >= b && b >= r)       begin sec = 2; num = b - r; end
            else if (g >= b)                 begin sec = 1; num = g - r; end
            else if (r >= g)                 begin sec = 4; num = r - g; end
            else                             begin sec = 3; num = b - g; end
`ifdef COLOUR_DECODE_ROUND_EN
            q = (num * 10922 + d / 2) / d;
`else
            q = (num * 10922) / d;
`endif
            ph  = sec * 10922 + q;
            lat = 15;
        end
    endtask

    // Count edges from the accepting edge (which is edge 1) until out_valid, bounded.
    task automatic wait_done(output int edges);
        edges = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            @(negedge clk);
            edges++;
        end
    endtask

    // Called at a negedge while idle; checks latency, result, hold and handshake.
    task automatic run_sample(input int r, input int g, input int b,
                              input int hold, input int fixed_ph, input string tag);
        int ep, el, elat, edges;
        model(r, g, b, ep, el, elat);
        red = 8'(r); green = 8'(g); blue = 8'(b); in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(edges);
        check({tag, "_latency"}, edges, elat);
        check({tag, "_phase"}, phase, ep);
        check({tag, "_log_mag"}, log_mag, el);
        if (fixed_ph >= 0) check({tag, "_phase_ref"}, phase, fixed_ph);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_phase"}, phase, ep);
            check({tag, "_hold_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, out_valid, 0);
    endtask

    initial begin
        int ph0, edges, ep, el, elat;
        int r, g, b;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        red = 8'd0; green = 8'd0; blue = 8'd0;
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_phase", phase, 0);
        check("rst_log_mag", log_mag, 0);
        @(negedge clk);
        reset = 1'b0;

        run_sample(255, 0, 0, 0, 0, "red");
        run_sample(255, 255, 0, 1, 10922, "yellow");
`ifdef COLOUR_DECODE_ROUND_EN
        run_sample(0, 128, 255, 0, 38206, "azure");
`else
        run_sample(0, 128, 255, 0, 38205, "azure");
`endif
        run_sample(100, 100, 100, 2, 0, "grey");
        run_sample(255, 0, 255, 0, -1, "magenta");
        run_sample(1, 0, 0, 0, 0, "tiny");

        // Backpressure: new sample waits while DONE is held.
        red = 8'd10; green = 8'd200; blue = 8'd50; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done(edges);
        check("bp_first_latency", edges, 15);
        ph0 = phase;
        red = 8'd30; green = 8'd60; blue = 8'd90; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_phase_stable", phase, ph0);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_edge1_in_ready", in_ready, 1);
        check("bp_edge1_out_valid", out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_edge2_accepted", in_ready, 0);
        model(30, 60, 90, ep, el, elat);
        wait_done(edges);
        check("bp_second_latency", edges, elat);
        check("bp_second_phase", phase, ep);
        check("bp_second_log_mag", log_mag, el);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Asynchronous reset during DIVIDE cycle 7.
        red = 8'd200; green = 8'd10; blue = 8'd100; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_phase", phase, 0);
        check("arst_log_mag", log_mag, 0);
        @(negedge clk);
        reset = 1'b0;
        run_sample(0, 255, 0, 0, 21844, "post_reset_green");

        // Randomized samples, every sixth one grey.
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 255);
            g = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            if (i % 6 == 0) begin
                g = r;
                b = r;
            end
            run_sample(r, g, b, $urandom_range(0, 3), -1, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
